inst_encoder: RTL and testbench
===============================

Name: inst_encoder

Overview:
- Producer end of the 16-bit instruction interface.
- Accepts decoded instruction fields (op, rd, rs, rb, disp4, imm, disp9) over a valid/ready handshake and packs them into the 16-bit instruction word the decode stage consumes.
- Writes each word into instruction memory at consecutive addresses from a programmable base.
- Used as the program loader ahead of fetch.

Parameters:
ADDR_W, 9, instruction memory address width
DEPTH, 512, maximum words per load session (1..2^ADDR_W)

Ports:
ck  input  1  clock, rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  one-cycle pulse: begin session, latch base_addr
base_addr  input  ADDR_W  first write address
in_valid  input  1  field tuple valid
in_ready  output  1  encoder can accept tuple
in_last  input  1  tuple is last of program
op  input  4  opcode
rd  input  4  destination / store-source register
rs  input  4  source register
rb  input  4  base register
disp4  input  4  load/store displacement
imm  input  8  immediate
disp9  input  9  jump displacement, bit 0 is MSB
mem_we  output  1  instruction memory write strobe
mem_addr  output  ADDR_W  write address
mem_wdata  output  16 [0:15]  encoded instruction word
count  output  ADDR_W+1  words written this session
busy  output  1  session active
done  output  1  session completed normally (level)
err  output  1  sticky: illegal tuple seen

Behaviour:
- Reset: async on rst high. State=IDLE. All outputs 0: in_ready, mem_we, mem_addr, mem_wdata, count, busy, done, err.
- States and transitions:
  - IDLE -> RUN on start.
  - RUN -> DONE on an accepted tuple with in_last.
  - RUN -> FULL when count reaches DEPTH without in_last.
  - DONE/FULL -> RUN on start.
  - start in any state restarts: count=0, addr=base_addr, err=0, done=0.
  - start takes priority over a same-cycle handshake; that tuple is dropped.
- Handshake:
  - in_ready = (state==RUN) && (count < DEPTH).
  - Transfer occurs when in_valid && in_ready on a rising edge.
- Encoding (word bits [0:15]). Unused bits are 0.
  - Operation class (op 0001, 0010, 0011, 0100, 0111): [12:15]=op, [8:11]=rd, [4:7]=rs, [0:3]=0.
  - Immediate class (op 0101, 0110, 1000): [12:15]=op, [8:11]=rd, [0:7]=imm.
  - Load/store class (op 1001, 1010, 1100, 1101): [12:15]=op, [8:11]=rd, [4:7]=rb, [0:3]=disp4.
  - Jump (op 1110): [12:15]=op, [8:11]=0, [0:7]=disp9[1:8]. disp9[0] must be 0.
- Illegal tuple: op 0000, 1011 or 1111, or jump with disp9[0]=1.
  - The tuple is consumed (handshake completes).
  - Nothing is written and count does not increment.
  - err is set and held until start or rst.
  - If in_last is set on an illegal tuple, the session still ends in DONE.
- Latency: a legal tuple accepted at edge N drives mem_we=1 with mem_addr and mem_wdata for exactly one cycle after edge N. count increments at edge N.
- Sustained throughput is 1 word per cycle.
- Address: mem_addr = (base_addr + count_before_write) mod 2^ADDR_W, wrapping silently.
- busy = 1 in RUN, and stays 1 through the final mem_we cycle.
- done = 1 in DONE.
- Reset mid-session: write is aborted, mem_we drops immediately, no partial state is kept.

Test Plan:
- Reset, then start with base_addr=0x010; send op=0001, rd=3, rs=5 (in_last=0), then op=0101, rd=2, imm=0xA5 (in_last=1). Required: mem_we pulses at addr 0x010, data (bits [0:15]) 0000_0101_0011_0001; then addr 0x011, data 1010_0101_0010_0101; count=2, done=1, in_ready=0.
- Load op=1010, rd=4, rb=7, disp4=9 -> data 1001_0111_0100_1010. Jump op=1110, disp9=0x03C -> data 0011_1100_0000_1110. err stays 0.
- Send op=1111, then jump with disp9=0x100. Required: both consumed, no mem_we, count unchanged, err=1 until the next start.
- DEPTH=4, base_addr=0x1FE, stream 5 tuples with in_valid held high and no in_last. Required: addrs 0x1FE, 0x1FF, 0x000, 0x001; in_ready=0 after the 4th; state FULL; 5th tuple not accepted.
- start asserted together with a valid tuple mid-session. Required: tuple dropped, count=0, next write at the new base.
- rst pulsed one cycle after a handshake. Required: no mem_we, all outputs 0 asynchronously.

Source files
------------

// File: rtl/inst_encoder.sv
// Program loader: packs decoded instruction fields into 16-bit words and
// writes them to instruction memory at consecutive addresses from a base.
module inst_encoder #(
  parameter int ADDR_W = 9,
  parameter int DEPTH  = 512
) (
  input  logic              ck,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_last,
  input  logic [3:0]        op,
  input  logic [3:0]        rd,
  input  logic [3:0]        rs,
  input  logic [3:0]        rb,
  input  logic [3:0]        disp4,
  input  logic [7:0]        imm,
  input  logic [0:8]        disp9,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [0:15]       mem_wdata,
  output logic [ADDR_W:0]   count,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] LAST_C  = (ADDR_W+1)'(DEPTH - 1);
  localparam logic [ADDR_W:0] ONE_C   = (ADDR_W+1)'(1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE,
    FULL
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] base_q;
  logic [0:15]       word;
  logic              legal;
  logic              accept;
  logic              write;

  // Field packing by opcode class; anything not listed is an illegal opcode.
  always_comb begin
    word  = '0;
    legal = 1'b1;
    case (op)
      4'b0001, 4'b0010, 4'b0011, 4'b0100, 4'b0111: begin
        word[12:15] = op;
        word[8:11]  = rd;
        word[4:7]   = rs;
      end
      4'b0101, 4'b0110, 4'b1000: begin
        word[12:15] = op;
        word[8:11]  = rd;
        word[0:7]   = imm;
      end
      4'b1001, 4'b1010, 4'b1100, 4'b1101: begin
        word[12:15] = op;
        word[8:11]  = rd;
        word[4:7]   = rb;
        word[0:3]   = disp4;
      end
      4'b1110: begin
        word[12:15] = op;
        word[0:7]   = disp9[1:8];
        legal       = ~disp9[0];
      end
      default: begin
        legal = 1'b0;
      end
    endcase
  end

  // A start pulse overrides any handshake in the same cycle.
  assign in_ready = (state == RUN) && (count < DEPTH_C);
  assign accept   = in_valid && in_ready && !start;
  assign write    = accept && legal;

  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (start) begin
      state_nxt = RUN;
    end else if (accept && in_last) begin
      state_nxt = DONE;
    end else if (write && (count == LAST_C)) begin
      state_nxt = FULL;
    end
  end

  // Write port and session counters; illegal tuples only raise err.
  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      count     <= '0;
      base_q    <= '0;
      err       <= 1'b0;
    end else begin
      mem_we <= write;
      if (start) begin
        count  <= '0;
        base_q <= base_addr;
        err    <= 1'b0;
      end else if (accept) begin
        if (legal) begin
          mem_addr  <= base_q + count[ADDR_W-1:0];
          mem_wdata <= word;
          count     <= count + ONE_C;
        end else begin
          err <= 1'b1;
        end
      end
    end
  end

  assign busy = (state == RUN) || mem_we;
  assign done = (state == DONE);

endmodule

// File: tb/tb_inst_encoder.sv
// Randomized bench for inst_encoder: a session-level model predicts every
// output each cycle, and directed scenarios pin known encodings and addresses.
module tb_inst_encoder;

  localparam int ADDR_W = 9;
  localparam int DEPTH  = 4;

  logic              ck = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] base_addr = '0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic              in_last = 1'b0;
  logic [3:0]        op = '0;
  logic [3:0]        rd = '0;
  logic [3:0]        rs = '0;
  logic [3:0]        rb = '0;
  logic [3:0]        disp4 = '0;
  logic [7:0]        imm = '0;
  logic [8:0]        d9 = '0;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [15:0]       wdata;
  logic [ADDR_W:0]   count;
  logic              busy;
  logic              done;
  logic              err;

  int checks = 0;
  int errors = 0;
  bit run_checks = 1'b0;

  // Model of the session: what the outputs must read after each edge.
  bit m_active = 0;
  bit m_done   = 0;
  bit m_err    = 0;
  bit m_we     = 0;
  int m_count  = 0;
  int m_base   = 0;
  int m_addr   = 0;
  int m_data   = 0;

  inst_encoder #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .ck(ck), .rst(rst), .start(start), .base_addr(base_addr),
    .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
    .op(op), .rd(rd), .rs(rs), .rb(rb), .disp4(disp4), .imm(imm),
    .disp9(d9), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(wdata),
    .count(count), .busy(busy), .done(done), .err(err)
  );

  always #5 ck = ~ck;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  task automatic check_output(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
    end
  endtask

  function automatic bit model_ready();
    return m_active && !m_done && (m_count < DEPTH);
  endfunction

  // Word value with bit 0 as the most significant: four nibbles [0:3]..[12:15].
  function automatic int encode(input int o, input int r_d, input int r_s, input int r_b,
                                input int d4, input int im, input int dj);
    if (o inside {1, 2, 3, 4, 7})   return r_s * 256 + r_d * 16 + o;
    if (o inside {5, 6, 8})         return im * 256 + r_d * 16 + o;
    if (o inside {9, 10, 12, 13})   return d4 * 4096 + r_b * 256 + r_d * 16 + o;
    return (dj % 256) * 256 + o;
  endfunction

  function automatic bit is_legal(input int o, input int dj);
    if (o inside {0, 11, 15}) return 0;
    if (o == 14) return dj < 256;
    return 1;
  endfunction

  task automatic model_reset();
    m_active = 0; m_done = 0; m_err = 0; m_we = 0;
    m_count = 0; m_base = 0; m_addr = 0; m_data = 0;
  endtask

  task automatic model_edge();
    if (start) begin
      m_active = 1; m_done = 0; m_count = 0; m_err = 0; m_we = 0;
      m_base = int'(base_addr);
    end else if (in_valid && model_ready()) begin
      if (is_legal(int'(op), int'(d9))) begin
        m_we    = 1;
        m_addr  = (m_base + m_count) % (1 << ADDR_W);
        m_data  = encode(int'(op), int'(rd), int'(rs), int'(rb), int'(disp4), int'(imm), int'(d9));
        m_count = m_count + 1;
      end else begin
        m_we  = 0;
        m_err = 1;
      end
      if (in_last) m_done = 1;
    end else begin
      m_we = 0;
    end
  endtask

  task automatic tick();
    @(posedge ck);
    if (!rst) model_edge();
    @(negedge ck);
  endtask

  task automatic apply_stimulus(input bit v, input bit l, input int o, input int r_d, input int r_s,
                                input int r_b, input int d4, input int im, input int dj);
    in_valid = v; in_last = l;
    op = 4'(o); rd = 4'(r_d); rs = 4'(r_s); rb = 4'(r_b);
    disp4 = 4'(d4); imm = 8'(im); d9 = 9'(dj);
  endtask

  task automatic begin_session(input int base);
    start = 1'b1; base_addr = ADDR_W'(base);
    tick();
    start = 1'b0;
  endtask

  // Reset lands between edges; outputs must clear before the next edge.
  task automatic pulse_reset();
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    check_output("rst_we", int'(mem_we), 0);
    check_output("rst_ready", int'(in_ready), 0);
    check_output("rst_count", int'(count), 0);
    check_output("rst_busy", int'(busy), 0);
    check_output("rst_done", int'(done), 0);
    check_output("rst_err", int'(err), 0);
    check_output("rst_addr", int'(mem_addr), 0);
    check_output("rst_data", int'(wdata), 0);
    start = 1'b0; in_valid = 1'b0;
    @(posedge ck);
    @(negedge ck);
    rst = 1'b0;
  endtask

  // Every negative edge compares the DUT against the model.
  always @(negedge ck) begin
    if (run_checks) begin
      check_output("in_ready", int'(in_ready), int'(model_ready()));
      check_output("mem_we", int'(mem_we), int'(m_we));
      check_output("count", int'(count), m_count);
      check_output("busy", int'(busy), int'(model_ready() || m_we));
      check_output("done", int'(done), int'(m_done));
      check_output("err", int'(err), int'(m_err));
      if (m_we) begin
        check_output("mem_addr", int'(mem_addr), m_addr);
        check_output("mem_wdata", int'(wdata), m_data);
      end
    end
  end

  initial begin
    int full_addr[4] = '{'h1FE, 'h1FF, 'h000, 'h001};
    model_reset();
    run_checks = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();

    // Two-instruction program at 0x010.
    begin_session('h010);
    apply_stimulus(1, 0, 1, 3, 5, 0, 0, 0, 0);
    tick();
    check_output("t1_addr0", int'(mem_addr), 'h010);
    check_output("t1_data0", int'(wdata), 'h0531);
    apply_stimulus(1, 1, 5, 2, 0, 0, 0, 'hA5, 0);
    tick();
    apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    check_output("t1_addr1", int'(mem_addr), 'h011);
    check_output("t1_data1", int'(wdata), 'hA525);
    check_output("t1_count", int'(count), 2);
    check_output("t1_done", int'(done), 1);
    check_output("t1_ready", int'(in_ready), 0);
    tick();

    // Load/store and jump encodings, then illegal tuples.
    begin_session('h020);
    apply_stimulus(1, 0, 'hA, 4, 0, 7, 9, 0, 0);
    tick();
    check_output("t2_ld_data", int'(wdata), 'h974A);
    apply_stimulus(1, 0, 'hE, 0, 0, 0, 0, 0, 'h03C);
    tick();
    check_output("t2_jmp_data", int'(wdata), 'h3C0E);
    check_output("t2_err0", int'(err), 0);
    apply_stimulus(1, 0, 'hF, 1, 1, 1, 1, 1, 0);
    tick();
    check_output("t3_ill_we", int'(mem_we), 0);
    apply_stimulus(1, 0, 'hE, 0, 0, 0, 0, 0, 'h100);
    tick();
    check_output("t3_jmp_we", int'(mem_we), 0);
    check_output("t3_err", int'(err), 1);
    check_output("t3_count", int'(count), 2);
    apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    check_output("t3_err_held", int'(err), 1);

    // Fill to DEPTH across the address wrap.
    begin_session('h1FE);
    for (int i = 0; i < 5; i++) begin
      apply_stimulus(1, 0, 2, i, i + 1, 0, 0, 0, 0);
      tick();
      if (i < 4) begin
        check_output("t4_we", int'(mem_we), 1);
        check_output("t4_addr", int'(mem_addr), full_addr[i]);
      end else begin
        check_output("t4_fifth_we", int'(mem_we), 0);
      end
      if (i == 3) check_output("t4_ready", int'(in_ready), 0);
    end
    apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();

    // Restart collides with a valid tuple.
    begin_session('h050);
    apply_stimulus(1, 0, 3, 1, 2, 0, 0, 0, 0);
    tick();
    start = 1'b1; base_addr = 'h070;
    tick();
    start = 1'b0;
    check_output("t5_count", int'(count), 0);
    check_output("t5_we", int'(mem_we), 0);
    tick();
    check_output("t5_addr", int'(mem_addr), 'h070);
    check_output("t5_we2", int'(mem_we), 1);

    // Reset right after a write was launched.
    pulse_reset();
    tick();

    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 199) == 0) begin
        pulse_reset();
      end else begin
        start = ((!m_active || m_done) && $urandom_range(0, 3) == 0) || ($urandom_range(0, 59) == 0);
        base_addr = ADDR_W'($urandom_range(0, 511));
        apply_stimulus($urandom_range(0, 9) < 7, $urandom_range(0, 9) == 0,
                       $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15),
                       $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 255),
                       $urandom_range(0, 511));
        tick();
      end
    end
    start = 1'b0;
    apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    run_checks = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
